// File: rtl/video_frame_monitor.sv
// video_frame_monitor: passive hsync/vsync/rgb tap measuring line length, lines per frame and a per-frame checksum.
module video_frame_monitor #(
    parameter int RGB_W      = 3,
    parameter int CNT_W      = 12,
    parameter int CHK_W      = 16,
    parameter int FRM_W      = 16,
    parameter int H_TOTAL    = 256,
    parameter int V_TOTAL    = 262,
    parameter bit SYNC_POL   = 1'b1,
    parameter int NUM_FRAMES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             display_on,
    input  logic [RGB_W-1:0] rgb,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic [CHK_W-1:0] frame_chk,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             frame_valid,
    output logic             h_err,
    output logic             v_err,
    output logic             done
);
    typedef enum logic [1:0] {SYNC_WAIT, MEASURE, DONE} state_t;
    state_t state_q, state_d;
    logic hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic hl_err_q, hl_err_d, skip_q, skip_d;
    logic fv_q, fv_d, herr_q, herr_d, verr_q, verr_d, done_q, done_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic [CHK_W-1:0] chk_q, chk_d, frame_chk_q, frame_chk_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic hs_act, vs_act, run, hs_edge, vs_edge, line_bad;
    logic [CNT_W-1:0] h_inc, v_inc, v_seen;
    logic [CHK_W-1:0] chk_pix, chk_next;
    always_comb begin
        hs_act   = hsync == SYNC_POL;
        vs_act   = vsync == SYNC_POL;
        run      = pix_en && state_q != DONE;
        hs_edge  = run && hs_act && !hs_prev_q;
        vs_edge  = run && vs_act && !vs_prev_q;
        h_inc    = &h_cnt_q ? h_cnt_q : h_cnt_q + CNT_W'(1);
        v_inc    = &v_cnt_q ? v_cnt_q : v_cnt_q + CNT_W'(1);
        // a line ending on the vsync sample still belongs to the closing frame
        v_seen   = hs_edge ? v_inc : v_cnt_q;
        line_bad = hs_edge && state_q == MEASURE && !skip_q && h_cnt_q != CNT_W'(H_TOTAL);
        chk_pix  = display_on ? CHK_W'(rgb) : '0;
        chk_next = ((chk_q << 1) | (chk_q >> (CHK_W - 1))) ^ chk_pix;
        state_d       = state_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        hl_err_d      = hl_err_q;
        skip_d        = skip_q;
        fv_d          = 1'b0;
        herr_d        = herr_q;
        verr_d        = verr_q;
        done_d        = done_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        chk_d         = chk_q;
        frame_chk_d   = frame_chk_q;
        frame_cnt_d   = frame_cnt_q;
        if (run) begin
            hs_prev_d  = hs_act;
            vs_prev_d  = vs_act;
            h_cnt_d    = hs_edge ? CNT_W'(1) : h_inc;
            line_len_d = hs_edge ? h_cnt_q : line_len_q;
            v_cnt_d    = v_seen;
            chk_d      = display_on ? chk_next : chk_q;
            hl_err_d   = hl_err_q | line_bad;
            skip_d     = (hs_edge && state_q == MEASURE) ? 1'b0 : skip_q;
            if (vs_edge) begin
                v_cnt_d = hs_edge ? CNT_W'(1) : '0;
                chk_d   = chk_pix;
                if (state_q == SYNC_WAIT) begin
                    state_d  = MEASURE;
                    skip_d   = 1'b1;
                    hl_err_d = 1'b0;
                    h_cnt_d  = hs_edge ? CNT_W'(1) : '0;
                end else begin
                    frame_lines_d = v_seen;
                    frame_chk_d   = chk_q;
                    frame_cnt_d   = frame_cnt_q + FRM_W'(1);
                    herr_d        = hl_err_q | line_bad;
                    verr_d        = v_seen != CNT_W'(V_TOTAL);
                    hl_err_d      = 1'b0;
                    fv_d          = 1'b1;
                    if (NUM_FRAMES != 0 && frame_cnt_d == FRM_W'(NUM_FRAMES)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SYNC_WAIT;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hl_err_q      <= 1'b0;
            skip_q        <= 1'b0;
            fv_q          <= 1'b0;
            herr_q        <= 1'b0;
            verr_q        <= 1'b0;
            done_q        <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            chk_q         <= '0;
            frame_chk_q   <= '0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hl_err_q      <= hl_err_d;
            skip_q        <= skip_d;
            fv_q          <= fv_d;
            herr_q        <= herr_d;
            verr_q        <= verr_d;
            done_q        <= done_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            chk_q         <= chk_d;
            frame_chk_q   <= frame_chk_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_chk   = frame_chk_q;
    assign frame_cnt   = frame_cnt_q;
    assign frame_valid = fv_q;
    assign h_err       = herr_q;
    assign v_err       = verr_q;
    assign done        = done_q;
endmodule

// File: tb/tb_video_frame_monitor.sv
// tb_video_frame_monitor: frame table plus scoreboard for an active-high and an inverted-sync instance.
module tb_video_frame_monitor;
    localparam int CNT_W = 12, CHK_W = 8, FRM_W = 16;
    logic clk = 1'b0, reset = 1'b1, pix_en = 1'b0, hsync = 1'b0, vsync = 1'b0, display_on = 1'b0;
    logic [2:0] rgb = '0;
    logic hsync_n, vsync_n;
    logic [CNT_W-1:0] a_line_len, a_frame_lines, b_line_len, b_frame_lines;
    logic [CHK_W-1:0] a_frame_chk, b_frame_chk;
    logic [FRM_W-1:0] a_frame_cnt, b_frame_cnt;
    logic a_fv, a_herr, a_verr, a_done, b_fv, b_herr, b_verr, b_done;
    assign hsync_n = ~hsync;
    assign vsync_n = ~vsync;
    always #5 clk = ~clk;
    video_frame_monitor #(.RGB_W(3), .CNT_W(CNT_W), .CHK_W(CHK_W), .FRM_W(FRM_W), .H_TOTAL(8),
        .V_TOTAL(4), .SYNC_POL(1'b1), .NUM_FRAMES(3)) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .rgb(rgb), .line_len(a_line_len), .frame_lines(a_frame_lines),
        .frame_chk(a_frame_chk), .frame_cnt(a_frame_cnt), .frame_valid(a_fv), .h_err(a_herr),
        .v_err(a_verr), .done(a_done));
    video_frame_monitor #(.RGB_W(3), .CNT_W(CNT_W), .CHK_W(CHK_W), .FRM_W(FRM_W), .H_TOTAL(8),
        .V_TOTAL(4), .SYNC_POL(1'b0), .NUM_FRAMES(3)) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync_n), .vsync(vsync_n),
        .display_on(1'b0), .rgb(rgb), .line_len(b_line_len), .frame_lines(b_frame_lines),
        .frame_chk(b_frame_chk), .frame_cnt(b_frame_cnt), .frame_valid(b_fv), .h_err(b_herr),
        .v_err(b_verr), .done(b_done));
    typedef struct {
        logic [CNT_W-1:0] lines;
        logic [CHK_W-1:0] chk;
        logic [FRM_W-1:0] cnt;
        logic herr;
        logic verr;
    } exp_t;
    typedef struct {
        bit rst;
        int nlines;
        int long_line;
        logic [2:0] seed;
        logic [2:0] inc;
        bit valid;
        int exp_lines;
        bit exp_herr;
        bit exp_verr;
        int exp_cnt;
    } row_t;
    int vectors = 0, miscompares = 0;
    exp_t sb[$];
    exp_t mon_e, last_e;
    row_t rows[8];
    logic [CHK_W-1:0] prev_chk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic put(input logic h, input logic v, input logic d, input logic [2:0] c);
        @(posedge clk); #1;
        pix_en = 1'b1; hsync = h; vsync = v; display_on = d; rgb = c;
        @(posedge clk); #1;
        pix_en = 1'b0; hsync = ~h; vsync = ~v; display_on = ~d; rgb = ~c;
    endtask
    // vsync spans line 0, hsync pulses at samples 5-6, pixels 0-5 visible
    task automatic drive_frame(input row_t r, output logic [CHK_W-1:0] c);
        logic [2:0] p;
        logic d;
        c = '0;
        for (int l = 0; l < r.nlines; l++)
            for (int i = 0; i < ((l == r.long_line) ? 9 : 8); i++) begin
                p = 3'(r.seed + r.inc * (l * 3 + i));
                d = i < 6;
                put(i == 5 || i == 6, l == 0, d, p);
                if (d) c = {c[CHK_W-2:0], c[CHK_W-1]} ^ {5'b0, p};
            end
    endtask
    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("rst_outputs_a", {a_line_len, a_frame_lines, a_frame_chk, a_frame_cnt, a_fv, a_herr, a_verr, a_done}, 64'd0);
        check("rst_outputs_b", {b_line_len, b_frame_lines, b_frame_chk, b_frame_cnt, b_fv, b_herr, b_verr, b_done}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0; display_on = 1'b0;
    endtask
    task automatic run_rows(input int lo, input int hi);
        exp_t e;
        for (int k = lo; k <= hi; k++) begin
            if (rows[k].rst) begin
                if (k > 0) repeat (3) put(1'b0, 1'b0, 1'b1, 3'd2);
                do_reset();
            end else if (rows[k-1].valid) begin
                e.lines = CNT_W'(rows[k-1].exp_lines);
                e.chk   = prev_chk;
                e.cnt   = FRM_W'(rows[k-1].exp_cnt);
                e.herr  = rows[k-1].exp_herr;
                e.verr  = rows[k-1].exp_verr;
                sb.push_back(e);
                last_e = e;
            end
            drive_frame(rows[k], prev_chk);
        end
    endtask
    always @(negedge clk) begin
        if (reset && (a_fv || b_fv)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame_valid: a=%0b b=%0b expected no pulse", a_fv, b_fv);
            end else begin
                mon_e = sb.pop_front();
                check("frame_valid_a", a_fv, 1);
                check("frame_valid_b", b_fv, 1);
                check("line_len_a", a_line_len, 8);
                check("line_len_b", b_line_len, 8);
                check("frame_lines_a", a_frame_lines, mon_e.lines);
                check("frame_lines_b", b_frame_lines, mon_e.lines);
                check("frame_chk_a", a_frame_chk, mon_e.chk);
                check("frame_chk_b", b_frame_chk, 0);
                check("frame_cnt_a", a_frame_cnt, mon_e.cnt);
                check("frame_cnt_b", b_frame_cnt, mon_e.cnt);
                check("h_err_a", a_herr, mon_e.herr);
                check("h_err_b", b_herr, mon_e.herr);
                check("v_err_a", a_verr, mon_e.verr);
                check("v_err_b", b_verr, mon_e.verr);
            end
        end
    end
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        rows[0] = '{1'b1, 4, -1, 3'd1, 3'd0, 1'b1, 4, 1'b0, 1'b0, 1};
        rows[1] = '{1'b0, 4,  1, 3'd3, 3'd1, 1'b1, 4, 1'b1, 1'b0, 2};
        rows[2] = '{1'b0, 4, -1, 3'd5, 3'd3, 1'b1, 4, 1'b0, 1'b0, 3};
        rows[3] = '{1'b0, 4, -1, 3'd2, 3'd1, 1'b0, 4, 1'b0, 1'b0, 0};
        rows[4] = '{1'b0, 4, -1, 3'd0, 3'd0, 1'b0, 4, 1'b0, 1'b0, 0};
        rows[5] = '{1'b1, 5, -1, 3'd6, 3'd5, 1'b1, 5, 1'b0, 1'b1, 1};
        rows[6] = '{1'b0, 4, -1, 3'd1, 3'd2, 1'b1, 4, 1'b0, 1'b0, 2};
        rows[7] = '{1'b0, 4, -1, 3'd0, 3'd0, 1'b0, 4, 1'b0, 1'b0, 0};
        run_rows(0, 4);
        @(negedge clk);
        check("done_a", a_done, 1);
        check("done_b", b_done, 1);
        check("frozen_cnt_a", a_frame_cnt, 3);
        check("frozen_chk_a", a_frame_chk, last_e.chk);
        check("frozen_lines_a", a_frame_lines, 4);
        check("frozen_line_len_a", a_line_len, 8);
        run_rows(5, 7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("not_done_a", a_done, 0);
        check("not_done_b", b_done, 0);
        check("final_cnt_a", a_frame_cnt, 2);
        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
